pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives the freeze inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the flush/bubble controls.
- Sources: data-hazard detection, taken branches, and a multi-cycle memory-access wait FSM.
- Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken-branch flush and data-hazard stalls, and counts frozen cycles.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT = 4,
    parameter int RA_W     = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   id_src1,
    input  logic [RA_W-1:0]   id_src2,
    input  logic              id_two_src,
    input  logic              exe_wb_en,
    input  logic [RA_W-1:0]   exe_dest,
    input  logic              exe_mem_r_en,
    input  logic              mem_wb_en,
    input  logic [RA_W-1:0]   mem_dest,
    input  logic              fwd_en,
    input  logic              mem_req,
    input  logic              branch_taken,
    output logic              if_freeze,
    output logic              id_freeze,
    output logic              exe_freeze,
    output logic              mem_freeze,
    output logic              if_flush,
    output logic              id_bubble,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] WC_LAST = 8'(MEM_WAIT - 1);

    state_t            state_reg, state_next;
    logic [7:0]        wc_reg, wc_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              mem_stall, mem_done;
    logic              e1, e2, m1, m2, hazard;
    logic              any_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wc_reg        <= 8'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            wc_reg    <= wc_next;
            if (any_freeze && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Memory wait FSM: wc counts the frozen cycles already spent on this access.
    always_comb begin
        state_next = state_reg;
        wc_next    = wc_reg;
        mem_stall  = 1'b0;
        mem_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    if (MEM_WAIT == 1) begin
                        mem_done = 1'b1;
                    end else begin
                        mem_stall  = 1'b1;
                        wc_next    = 8'd1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wc_reg < WC_LAST) begin
                    mem_stall = 1'b1;
                    wc_next   = wc_reg + 8'd1;
                end else begin
                    mem_done   = 1'b1;
                    wc_next    = 8'd0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                wc_next    = 8'd0;
            end
        endcase
    end

    always_comb begin
        e1 = exe_wb_en & (id_src1 == exe_dest);
        e2 = exe_wb_en & id_two_src & (id_src2 == exe_dest);
        m1 = mem_wb_en & (id_src1 == mem_dest);
        m2 = mem_wb_en & id_two_src & (id_src2 == mem_dest);
        // With forwarding only a load result in EX cannot be bypassed in time.
        if (fwd_en)
            hazard = exe_mem_r_en & (e1 | e2);
        else
            hazard = e1 | e2 | m1 | m2;
    end

    always_comb begin
        if_freeze  = 1'b0;
        id_freeze  = 1'b0;
        exe_freeze = 1'b0;
        mem_freeze = 1'b0;
        if_flush   = 1'b0;
        id_bubble  = 1'b0;
        mem_ready  = 1'b0;
        if (!rst) begin
            mem_ready = mem_done;
            if (mem_stall) begin
                if_freeze  = 1'b1;
                id_freeze  = 1'b1;
                exe_freeze = 1'b1;
                mem_freeze = 1'b1;
            end else if (branch_taken) begin
                if_flush  = 1'b1;
                id_bubble = 1'b1;
            end else if (hazard) begin
                if_freeze = 1'b1;
                id_bubble = 1'b1;
            end
        end
    end

    assign any_freeze = if_freeze | id_freeze | exe_freeze | mem_freeze;
    assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed scoreboard bench for pipe_hazard_ctrl over three
// parameter sets (MEM_WAIT=4/CNT_W=16, MEM_WAIT=4/CNT_W=4, MEM_WAIT=1/CNT_W=16).
module tb_pipe_hazard_ctrl;

    localparam int NI = 3;
    localparam int MWS [NI] = '{4, 4, 1};
    localparam int CWS [NI] = '{16, 4, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       fwd_en, mem_req, branch_taken;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    // {if_freeze, id_freeze, exe_freeze, mem_freeze, if_flush, id_bubble, mem_ready}
    logic [6:0]  act_o [NI];
    logic [15:0] act_c [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic              f_if, f_id, f_ex, f_mem, fl, bub, rdy;
        logic [CWS[gi]-1:0] cnt;
        pipe_hazard_ctrl #(.MEM_WAIT(MWS[gi]), .RA_W(4), .CNT_W(CWS[gi])) u_dut (
            .clk(clk), .rst(rst),
            .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
            .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
            .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .fwd_en(fwd_en),
            .mem_req(mem_req), .branch_taken(branch_taken),
            .if_freeze(f_if), .id_freeze(f_id), .exe_freeze(f_ex), .mem_freeze(f_mem),
            .if_flush(fl), .id_bubble(bub), .mem_ready(rdy), .stall_cnt(cnt)
        );
        assign act_o[gi] = {f_if, f_id, f_ex, f_mem, fl, bub, rdy};
        assign act_c[gi] = 16'(cnt);
    end

    typedef struct packed {
        logic [NI-1:0][6:0]  o;
        logic [NI-1:0][15:0] c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;
    bit   done    = 1'b0;

    // Reference model: left = cycles remaining in the current access (0 = idle),
    // the final remaining cycle being the release cycle.
    int left [NI];
    int cnt  [NI];

    function automatic logic [6:0] exp_out(int i);
        logic ms, mr, hz, e1, e2, m1, m2;
        if (rst) return 7'd0;
        ms = (left[i] > 1) || (left[i] == 0 && mem_req && MWS[i] > 1);
        mr = (left[i] == 1) || (left[i] == 0 && mem_req && MWS[i] == 1);
        e1 = exe_wb_en && id_src1 == exe_dest;
        e2 = exe_wb_en && id_two_src && id_src2 == exe_dest;
        m1 = mem_wb_en && id_src1 == mem_dest;
        m2 = mem_wb_en && id_two_src && id_src2 == mem_dest;
        hz = fwd_en ? (exe_mem_r_en && (e1 || e2)) : (e1 || e2 || m1 || m2);
        if (ms)           return 7'b1111_000;
        if (branch_taken) return {6'b0000_11, mr};
        if (hz)           return {6'b1000_01, mr};
        return {6'b0, mr};
    endfunction

    task automatic step();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            e.o[i] = exp_out(i);
            e.c[i] = 16'(cnt[i]);
        end
        q.push_back(e);
        started = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                left[i] = 0;
                cnt[i]  = 0;
            end else begin
                if (e.o[i][6:3] != 4'b0 && cnt[i] < (1 << CWS[i]) - 1) cnt[i]++;
                if (left[i] > 0) left[i]--;
                else if (mem_req && MWS[i] > 1) left[i] = MWS[i] - 1;
            end
        end
        #1;
    endtask

    task automatic clear_in();
        rst = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        fwd_en = 0; mem_req = 0; branch_taken = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    always @(negedge clk) begin
        if (started && !done) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL queue_empty: no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    total++;
                    if (act_o[i] !== e.o[i]) begin
                        bad++;
                        $display("FAIL ctrl[%0d] t=%0t got=%b want=%b", i, $time, act_o[i], e.o[i]);
                    end
                    total++;
                    if (act_c[i] !== e.c[i]) begin
                        bad++;
                        $display("FAIL stall_cnt[%0d] t=%0t got=%0d want=%0d", i, $time, act_c[i], e.c[i]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin left[i] = 0; cnt[i] = 0; end
        clear_in();
        rst = 1;
        @(posedge clk); #1;
        steps(2);
        rst = 0;
        step();
        // single access
        mem_req = 1; step(); mem_req = 0; steps(5);
        // exe hazard without/with forwarding
        id_src1 = 3; exe_wb_en = 1; exe_dest = 3; steps(2);
        fwd_en = 1; steps(2);
        exe_mem_r_en = 1; steps(2);
        // second source gating
        clear_in(); id_src1 = 1; id_src2 = 5; exe_dest = 5; exe_wb_en = 1; steps(2);
        id_two_src = 1; steps(2);
        // mem-stage hazard
        clear_in(); id_src1 = 7; mem_wb_en = 1; mem_dest = 7; steps(2);
        // branch with hazard, then branch during wait
        branch_taken = 1; steps(2);
        clear_in(); mem_req = 1; step(); mem_req = 0; branch_taken = 1; steps(4);
        clear_in(); step();
        // reset mid-wait then full access
        mem_req = 1; step(); mem_req = 0; step(); rst = 1; step(); rst = 0; step();
        mem_req = 1; step(); mem_req = 0; steps(4);
        // back-to-back accesses and continuous requests
        mem_req = 1; steps(12); mem_req = 0; steps(2);
        // continuous hazard: saturates the 4-bit counter
        id_src1 = 2; exe_wb_en = 1; exe_dest = 2; steps(20);
        clear_in(); steps(2);
        // random traffic
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(99) < 2);
            id_src1      = 4'($urandom_range(3));
            id_src2      = 4'($urandom_range(3));
            exe_dest     = 4'($urandom_range(3));
            mem_dest     = 4'($urandom_range(3));
            id_two_src   = 1'($urandom_range(1));
            exe_wb_en    = 1'($urandom_range(1));
            mem_wb_en    = 1'($urandom_range(1));
            exe_mem_r_en = 1'($urandom_range(1));
            fwd_en       = 1'($urandom_range(1));
            mem_req      = ($urandom_range(99) < 20);
            branch_taken = ($urandom_range(99) < 15);
            step();
        end
        done = 1'b1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: queue size got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
